// File: rtl/rom_arb_pkg.sv
// Shared types and default widths for the image ROM arbiter.
// The widths fit a 4:4:4 RGB pixel ROM with 4096 entries.
package rom_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 12;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_A,
    GNT_B
  } grant_t;

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side bundle of the ROM arbiter: two read request/response channels plus the priority select.
interface rom_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              prio_a;
  logic              req_a;
  logic [ADDR_W-1:0] addr_a;
  logic              gnt_a;
  logic              rvalid_a;
  logic [DATA_W-1:0] rdata_a;
  logic              req_b;
  logic [ADDR_W-1:0] addr_b;
  logic              gnt_b;
  logic              rvalid_b;
  logic [DATA_W-1:0] rdata_b;

  modport slave (
    input  prio_a, req_a, addr_a, req_b, addr_b,
    output gnt_a, rvalid_a, rdata_a, gnt_b, rvalid_b, rdata_b
  );

  modport master (
    output prio_a, req_a, addr_a, req_b, addr_b,
    input  gnt_a, rvalid_a, rdata_a, gnt_b, rvalid_b, rdata_b
  );

endinterface

// File: rtl/rom_arb_tag_pipe.sv
// Shift register of grant tags that tracks reads in flight through the address register and the ROM.
// A grant in cycle N emerges from the last stage in cycle N+1+ROM_LAT.
module rom_arb_tag_pipe
  import rom_arb_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  grant_t sel,
  output logic   rvalid_a,
  output logic   rvalid_b
);

  grant_t stages [ROM_LAT:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= ROM_LAT; i++) begin
        stages[i] <= GNT_NONE;
      end
    end else begin
      stages[0] <= sel;
      for (int i = 1; i <= ROM_LAT; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign rvalid_a = (stages[ROM_LAT] == GNT_A);
  assign rvalid_b = (stages[ROM_LAT] == GNT_B);

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a single image ROM: strict or round-robin priority,
// with a starvation guard that forces a grant to B after MAX_WAIT denied cycles.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ROM_LAT  = 1,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  rom_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rgb
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  grant_t     sel;
  grant_t     last_gnt;
  logic [7:0] wait_cnt;
  logic       force_b;

  assign force_b = (wait_cnt == WAIT_LIMIT);

  // Grants are gated by reset so nothing is accepted while the pipeline is held clear.
  always_comb begin
    sel = GNT_NONE;
    if (rst) begin
      if (bus.req_a && bus.req_b) begin
        if (force_b)                sel = GNT_B;
        else if (bus.prio_a)        sel = GNT_A;
        else if (last_gnt == GNT_A) sel = GNT_B;
        else                        sel = GNT_A;
      end else if (bus.req_a) begin
        sel = GNT_A;
      end else if (bus.req_b) begin
        sel = GNT_B;
      end
    end
  end

  assign bus.gnt_a = (sel == GNT_A);
  assign bus.gnt_b = (sel == GNT_B);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr <= '0;
      last_gnt <= GNT_B;
      wait_cnt <= '0;
    end else begin
      case (sel)
        GNT_A: begin
          rom_addr <= bus.addr_a;
          last_gnt <= GNT_A;
        end
        GNT_B: begin
          rom_addr <= bus.addr_b;
          last_gnt <= GNT_B;
        end
        default: ;
      endcase
      if (sel == GNT_B)
        wait_cnt <= '0;
      else if (bus.req_b && !force_b)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  rom_arb_tag_pipe #(
    .ROM_LAT (ROM_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .rvalid_a (bus.rvalid_a),
    .rvalid_b (bus.rvalid_b)
  );

  // ROM data is shared; only rvalid says whose it is.
  assign bus.rdata_a = rom_rgb;
  assign bus.rdata_b = rom_rgb;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: one instance with ROM_LAT=1 for the main checks,
// a second with ROM_LAT=3 for the long-latency read.
module tb_rom_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total;
  int   bad;

  always #5 clk = ~clk;

  rom_arbiter_if #(.ADDR_W(12), .DATA_W(12)) bus0 ();
  rom_arbiter_if #(.ADDR_W(12), .DATA_W(12)) bus1 ();

  logic [11:0] rom_addr0, rom_rgb0, q0;
  logic [11:0] rom_addr1, rom_rgb1, q1a, q1b, q1c;

  rom_arbiter #(.ADDR_W(12), .DATA_W(12), .ROM_LAT(1), .MAX_WAIT(15)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus0),
    .rom_addr (rom_addr0),
    .rom_rgb  (rom_rgb0)
  );

  rom_arbiter #(.ADDR_W(12), .DATA_W(12), .ROM_LAT(3), .MAX_WAIT(15)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus1),
    .rom_addr (rom_addr1),
    .rom_rgb  (rom_rgb1)
  );

  // ROM contents: (addr*7) ^ 0x0A5, truncated to 12 bits
  function automatic logic [11:0] rom_f(input logic [11:0] a);
    logic [15:0] t;
    t = {4'h0, a} * 16'd7;
    return t[11:0] ^ 12'h0A5;
  endfunction

  always @(posedge clk) begin
    q0  <= rom_f(rom_addr0);
    q1a <= rom_f(rom_addr1);
    q1b <= q1a;
    q1c <= q1b;
  end
  assign rom_rgb0 = q0;
  assign rom_rgb1 = q1c;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic pa, input logic ra, input logic [11:0] aa,
                               input logic rb, input logic [11:0] ab);
    @(negedge clk);
    bus0.prio_a = pa;
    bus0.req_a  = ra;
    bus0.addr_a = aa;
    bus0.req_b  = rb;
    bus0.addr_b = ab;
    #1;
  endtask

  task automatic stepB1(input logic rb, input logic [11:0] ab);
    @(negedge clk);
    bus1.req_b  = rb;
    bus1.addr_b = ab;
    #1;
  endtask

  task automatic resetPulse();
    @(negedge clk);
    rst = 1'b0;
    bus0.req_a = 1'b0;
    bus0.req_b = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus0.prio_a = 1'b0; bus0.req_a = 1'b1; bus0.addr_a = 12'h123;
    bus0.req_b  = 1'b0; bus0.addr_b = 12'h000;
    bus1.prio_a = 1'b0; bus1.req_a = 1'b0; bus1.addr_a = 12'h000;
    bus1.req_b  = 1'b0; bus1.addr_b = 12'h000;

    // reset state, with a request pending that must not be granted
    @(negedge clk);
    #1;
    checkOutput("rst_gnt_a", 32'(bus0.gnt_a), 32'd0);
    checkOutput("rst_gnt_b", 32'(bus0.gnt_b), 32'd0);
    checkOutput("rst_rvalid_a", 32'(bus0.rvalid_a), 32'd0);
    checkOutput("rst_rom_addr", 32'(rom_addr0), 32'h000);
    checkOutput("rst_wait_cnt", 32'(dut0.wait_cnt), 32'd0);

    // single A read, granted in the first cycle after release
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("a1_gnt_a", 32'(bus0.gnt_a), 32'd1);
    checkOutput("a1_gnt_b", 32'(bus0.gnt_b), 32'd0);
    applyStimulus(0, 0, 12'h000, 0, 12'h000);
    checkOutput("a1_rom_addr", 32'(rom_addr0), 32'h123);
    checkOutput("a1_rvalid_early", 32'(bus0.rvalid_a), 32'd0);
    applyStimulus(0, 0, 12'h000, 0, 12'h000);
    checkOutput("a1_rvalid", 32'(bus0.rvalid_a), 32'd1);
    checkOutput("a1_rdata", 32'(bus0.rdata_a), 32'h750);
    applyStimulus(0, 0, 12'h000, 0, 12'h000);
    checkOutput("a1_rvalid_once", 32'(bus0.rvalid_a), 32'd0);

    // round-robin: A,B,A,B,A,B and responses two cycles later
    resetPulse();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, k < 6, 12'h010, k < 6, 12'h020);
      checkOutput($sformatf("rr_gnt_a_%0d", k), 32'(bus0.gnt_a), 32'(k < 6 && k % 2 == 0));
      checkOutput($sformatf("rr_gnt_b_%0d", k), 32'(bus0.gnt_b), 32'(k < 6 && k % 2 == 1));
      checkOutput($sformatf("rr_rvalid_a_%0d", k), 32'(bus0.rvalid_a), 32'(k >= 2 && k % 2 == 0));
      checkOutput($sformatf("rr_rvalid_b_%0d", k), 32'(bus0.rvalid_b), 32'(k >= 2 && k % 2 == 1));
      if (k >= 2 && k % 2 == 0) checkOutput($sformatf("rr_rdata_a_%0d", k), 32'(bus0.rdata_a), 32'h0D5);
      if (k >= 2 && k % 2 == 1) checkOutput($sformatf("rr_rdata_b_%0d", k), 32'(bus0.rdata_b), 32'h045);
    end

    // strict priority with forced B grant after 15 denied cycles
    resetPulse();
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1, 1, 12'h100, 1, 12'h200);
      checkOutput($sformatf("pr_gnt_a_%0d", k), 32'(bus0.gnt_a), 32'(k != 15));
      checkOutput($sformatf("pr_gnt_b_%0d", k), 32'(bus0.gnt_b), 32'(k == 15));
      if (k == 15) checkOutput("pr_wait_sat", 32'(dut0.wait_cnt), 32'd15);
      if (k == 16) checkOutput("pr_wait_clr", 32'(dut0.wait_cnt), 32'd0);
    end

    // priority select takes effect in the same cycle
    applyStimulus(0, 1, 12'h100, 1, 12'h200);
    checkOutput("pflip_rr_b", 32'(bus0.gnt_b), 32'd1);
    applyStimulus(1, 1, 12'h100, 1, 12'h200);
    checkOutput("pflip_prio_a", 32'(bus0.gnt_a), 32'd1);
    applyStimulus(0, 1, 12'h100, 1, 12'h200);
    checkOutput("pflip_rr_b2", 32'(bus0.gnt_b), 32'd1);
    applyStimulus(1, 0, 12'h000, 1, 12'h300);
    checkOutput("solo_b_gnt", 32'(bus0.gnt_b), 32'd1);
    checkOutput("solo_b_gnt_a", 32'(bus0.gnt_a), 32'd0);
    applyStimulus(0, 0, 12'h000, 0, 12'h000);
    applyStimulus(0, 0, 12'h000, 0, 12'h000);
    applyStimulus(0, 0, 12'h000, 0, 12'h000);

    // reset right after a grant discards the in-flight read
    applyStimulus(0, 1, 12'h055, 0, 12'h000);
    checkOutput("mid_gnt_a", 32'(bus0.gnt_a), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus0.req_a = 1'b0;
    #1;
    checkOutput("mid_rom_addr", 32'(rom_addr0), 32'h000);
    checkOutput("mid_wait_cnt", 32'(dut0.wait_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 12'h000, 0, 12'h000);
      checkOutput($sformatf("mid_no_rvalid_%0d", k), 32'(bus0.rvalid_a), 32'd0);
    end

    // ROM_LAT=3 instance: B read of the top address
    stepB1(1, 12'hFFF);
    checkOutput("l3_gnt_b", 32'(bus1.gnt_b), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      stepB1(0, 12'h000);
      checkOutput($sformatf("l3_rvalid_b_%0d", k), 32'(bus1.rvalid_b), 32'(k == 4));
      if (k == 4) checkOutput("l3_rdata_b", 32'(bus1.rdata_b), 32'hF5C);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
